io_bridge: RTL and testbench
============================

IO_BRIDGE -- requirements
Module: io_bridge

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk_in input 1 (all state on rising edge); rst_in input 1 (synchronous, active-low).
REQ-002 SHALL have port: rdy_in  input  1  global ready; low freezes all state.
REQ-003 SHALL have CPU-side ports: cpu_a input 32 address (17:0 used); cpu_dout input 8 write byte; cpu_wr input 1 (1=write); cpu_din output 8 read byte; io_buffer_full output 1 TX back-pressure.
REQ-004 SHALL have RAM-side ports: ram_a output 17 address; ram_din output 8 write byte; ram_wr output 1 write strobe; ram_dout input 8 read byte, valid the cycle after the address.
REQ-005 SHALL have UART-side ports: tx_data output 8; tx_valid output 1; tx_ready input 1; rx_data input 8; rx_valid input 1 (byte available); rx_pop output 1 (consume byte).
REQ-006 SHALL have port: program_stop output 1, sticky stop flag.

Function
REQ-007 SHALL decode IO space as cpu_a[17:16]==2'b11 and RAM space otherwise.
REQ-008 SHALL drive ram_a=cpu_a[16:0] and ram_din=cpu_dout combinationally, with ram_wr=cpu_wr only for RAM space and rdy_in high, else 0.
REQ-009 SHALL register a 1-cycle read-source select (RAM, RX, CNT); cpu_din SHALL return the selected source the cycle after the address (fixed latency 1 for all reads).
REQ-010 SHALL, on read of 0x30000 with rx_valid=1, pulse rx_pop for one cycle and latch rx_data; with rx_valid=0, no pop and read data 0x00.
REQ-011 SHALL maintain a 32-bit cycle counter, incrementing only when rdy_in is high, wrapping 0xFFFFFFFF->0.
REQ-012 SHALL, on read of 0x30004, snapshot the counter and return byte 0; reads of 0x30005..0x30007 SHALL return bytes 1..3 of that snapshot, giving a coherent little-endian word.
REQ-013 SHALL, on write of 0x30000 with nonzero data, push the byte into a 16-entry TX FIFO; 0x00 writes SHALL be dropped.
REQ-014 SHALL, on write of 0x30004, push 0x00 into the TX FIFO and set program_stop; later IO writes SHALL be ignored.
REQ-015 SHALL present the FIFO head as tx_data with tx_valid=!empty; pop on tx_valid&&tx_ready.
REQ-016 SHALL assert io_buffer_full when FIFO count >=14 (two-entry margin for an in-flight write).
REQ-017 SHALL, on push to a full FIFO, drop the byte without corrupting contents; simultaneous push and pop at full or empty SHALL keep count unchanged.
REQ-018 SHALL, with rdy_in low, cause no FIFO push, rx_pop, snapshot, or counter change; TX pops SHALL continue.
REQ-019 SHALL ignore unmapped IO addresses (writes no effect, reads 0x00).

Reset
REQ-020 SHALL, with rst_in low at a clock edge, clear counter, snapshot, FIFO pointers/count, program_stop, and read select (RAM).
REQ-021 SHALL hold outputs during reset at: tx_valid=0, rx_pop=0, io_buffer_full=0, program_stop=0, cpu_din=0x00, ram_wr=0.
REQ-022 SHALL, when reset occurs mid-drain, discard FIFO contents with no partial byte presented.

Configuration
REQ-023 SHALL compile the RX read path only with macro IO_BRIDGE_RX_EN defined; without it, rx_pop SHALL be tied 0 and 0x30000 reads SHALL return 0x00.

Structure
REQ-024 SHALL take IO base, register offsets (0x30000, 0x30004), FIFO depth, full threshold, and read-select encoding from the shared config package/header.
REQ-025 SHALL implement the TX FIFO as sub-module io_tx_fifo (parameterised depth/width, count output).

Verification
REQ-026 SHALL cover: writes 0x48, 0x00, 0x69 to 0x30000 with tx_ready=1 -> tx stream 0x48, 0x69 only.
REQ-027 SHALL cover: tx_ready=0, 14 nonzero writes -> io_buffer_full=1 after 14th; 17th write dropped; drained order intact.
REQ-028 SHALL cover: counter preset near 0xFFFFFFFE, read 0x30004..0x30007 across wrap -> bytes from one snapshot.
REQ-029 SHALL cover: RAM write 0xA5 to 0x00100 then read -> cpu_din=0xA5 one cycle after address.
REQ-030 SHALL cover: write 0x30004 -> tx byte 0x00, program_stop=1; later 0x30000 write 0x41 ignored; rst_in low -> program_stop=0.
REQ-031 SHALL cover: rdy_in low during 0x30000 read with rx_valid=1 -> no rx_pop and counter frozen.

Source files
------------

// File: rtl/io_bridge_pkg.sv
// Shared address map, TX FIFO sizing and read-source encoding for io_bridge.
// The RX read path is built only when IO_BRIDGE_RX_EN is defined.
package io_bridge_pkg;

    localparam int unsigned ADDR_W   = 18;
    localparam int unsigned RAM_AW   = 17;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned CNT_W    = 32;

    localparam logic [1:0]        IO_SPACE  = 2'b11;
    localparam logic [ADDR_W-1:0] ADDR_UART = 18'h30000;
    localparam logic [ADDR_W-1:0] ADDR_CNT  = 18'h30004;

    localparam int unsigned TX_DEPTH   = 16;
    localparam int unsigned TX_FULL_TH = 14;
    localparam int unsigned TX_CNT_W   = $clog2(TX_DEPTH + 1);

    typedef enum logic [1:0] {
        SEL_RAM  = 2'd0,
        SEL_RX   = 2'd1,
        SEL_CNT  = 2'd2,
        SEL_ZERO = 2'd3
    } rd_sel_e;

    // Little-endian byte lane of a counter snapshot.
    function automatic logic [DATA_W-1:0] cnt_byte(input logic [CNT_W-1:0] w,
                                                   input logic [1:0]       idx);
        logic [DATA_W-1:0] b;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// Synchronous FIFO with occupancy count; pushes to a full FIFO are dropped
// unless a pop frees a slot in the same cycle.
module io_tx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             din_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             dout_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push_c, pop_c;

    always_comb begin
        pop_c  = pop_i && (cnt_q != '0);
        push_c = push_i && ((cnt_q != CW'(DEPTH)) || pop_c);
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_c) begin
            wptr_d = (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + AW'(1);
        end
        if (pop_c) begin
            rptr_d = (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + AW'(1);
        end
        case ({push_c, pop_c})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: pointers define what is valid.
    always_ff @(posedge clk_in) begin
        if (push_c) begin
            mem_q[wptr_q] <= din_i;
        end
    end

    assign dout_o  = mem_q[rptr_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;

endmodule

// File: rtl/io_bridge.sv
// CPU-to-RAM/UART bridge: address decode, 1-cycle read mux, cycle counter, TX FIFO.
// Define IO_BRIDGE_RX_EN to build the UART RX read path at 0x30000.
module io_bridge
    import io_bridge_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic [16:0] ram_a,
    output logic [7:0]  ram_din,
    output logic        ram_wr,
    input  logic [7:0]  ram_dout,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic        program_stop
);

    rd_sel_e             sel_q, sel_d;
    logic [1:0]          byte_q, byte_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    snap_q, snap_d;
    logic [DATA_W-1:0]   rxb_q, rxb_d;
    logic                stop_q, stop_d;

    logic                io_sel, hit_uart, hit_cnt, hit_cnt_wr;
    logic                push_c, rx_pop_c;
    logic [DATA_W-1:0]   push_data_c, rd_data_c;
    logic                fifo_empty, fifo_full, tx_pop;
    logic [TX_CNT_W-1:0] tx_count;

    assign io_sel     = (cpu_a[17:16] == IO_SPACE);
    assign hit_uart   = (cpu_a[17:0] == ADDR_UART);
    assign hit_cnt    = (cpu_a[17:2] == ADDR_CNT[17:2]);
    assign hit_cnt_wr = (cpu_a[17:0] == ADDR_CNT);

    assign ram_a   = cpu_a[RAM_AW-1:0];
    assign ram_din = cpu_dout;
    assign ram_wr  = rst_in && rdy_in && cpu_wr && !io_sel;

    // Next-state: every state change waits for rdy_in.
    always_comb begin
        sel_d       = sel_q;
        byte_d      = byte_q;
        cnt_d       = cnt_q;
        snap_d      = snap_q;
        rxb_d       = rxb_q;
        stop_d      = stop_q;
        push_c      = 1'b0;
        push_data_c = cpu_dout;
        rx_pop_c    = 1'b0;
        if (rst_in && rdy_in) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!cpu_wr) begin
                byte_d = cpu_a[1:0];
                if (!io_sel) begin
                    sel_d = SEL_RAM;
                end else if (hit_uart) begin
`ifdef IO_BRIDGE_RX_EN
                    sel_d    = SEL_RX;
                    rx_pop_c = rx_valid;
                    rxb_d    = rx_valid ? rx_data : '0;
`else
                    sel_d    = SEL_ZERO;
`endif
                end else if (hit_cnt) begin
                    sel_d = SEL_CNT;
                    if (cpu_a[1:0] == 2'b00) begin
                        snap_d = cnt_q;
                    end
                end else begin
                    sel_d = SEL_ZERO;
                end
            end else begin
                sel_d = SEL_ZERO;
                if (io_sel && !stop_q) begin
                    if (hit_uart && (cpu_dout != '0)) begin
                        push_c = 1'b1;
                    end else if (hit_cnt_wr) begin
                        push_c      = 1'b1;
                        push_data_c = '0;
                        stop_d      = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            sel_q  <= SEL_RAM;
            byte_q <= '0;
            cnt_q  <= '0;
            snap_q <= '0;
            rxb_q  <= '0;
            stop_q <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            byte_q <= byte_d;
            cnt_q  <= cnt_d;
            snap_q <= snap_d;
            rxb_q  <= rxb_d;
            stop_q <= stop_d;
        end
    end

    // Read data follows the source selected by last cycle's address.
    always_comb begin
        rd_data_c = '0;
        case (sel_q)
            SEL_RAM: rd_data_c = ram_dout;
            SEL_RX:  rd_data_c = rxb_q;
            SEL_CNT: rd_data_c = cnt_byte(snap_q, byte_q);
            default: rd_data_c = '0;
        endcase
    end

    assign cpu_din      = rst_in ? rd_data_c : '0;
    assign rx_pop       = rx_pop_c;
    assign program_stop = rst_in && stop_q;

    io_tx_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (DATA_W)
    ) u_tx_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .push_i  (push_c),
        .din_i   (push_data_c),
        .pop_i   (tx_pop),
        .dout_o  (tx_data),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (tx_count)
    );

    assign tx_valid       = rst_in && !fifo_empty;
    assign tx_pop         = tx_valid && tx_ready;
    assign io_buffer_full = rst_in && (tx_count >= TX_CNT_W'(TX_FULL_TH));

    logic unused_c;
`ifdef IO_BRIDGE_RX_EN
    assign unused_c = &{1'b0, cpu_a[31:18], fifo_full};
`else
    assign unused_c = &{1'b0, cpu_a[31:18], fifo_full, rx_data, rx_valid};
`endif

endmodule

// File: tb/tb_io_bridge.sv
// Scoreboard bench for io_bridge: stimulus queues expected read bytes and TX bytes,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_io_bridge;

`ifdef IO_BRIDGE_RX_EN
    localparam bit RX_EN = 1'b1;
`else
    localparam bit RX_EN = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic [31:0] cpu_a = '0;
    logic [7:0]  cpu_dout = '0;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [16:0] ram_a;
    logic [7:0]  ram_din;
    logic        ram_wr;
    logic [7:0]  ram_dout = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_pop;
    logic        program_stop;

    int          n_chk = 0;
    int          n_err = 0;
    logic [7:0]  rd_q[$];
    logic [7:0]  tx_q[$];
    logic        rd_tag = 1'b0;
    logic        rd_tag_d = 1'b0;
    logic [7:0]  ram_mem [0:131071];

    io_bridge dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .cpu_a          (cpu_a),
        .cpu_dout       (cpu_dout),
        .cpu_wr         (cpu_wr),
        .cpu_din        (cpu_din),
        .io_buffer_full (io_buffer_full),
        .ram_a          (ram_a),
        .ram_din        (ram_din),
        .ram_wr         (ram_wr),
        .ram_dout       (ram_dout),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_pop         (rx_pop),
        .program_stop   (program_stop)
    );

    always #5 clk_in = ~clk_in;

    // RAM with one-cycle read latency.
    always @(posedge clk_in) begin
        if (ram_wr) ram_mem[ram_a] <= ram_din;
        ram_dout <= ram_mem[ram_a];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk_in) rd_tag_d <= rd_tag;

    // Monitor: read data one cycle after a tagged address, TX bytes on handshake.
    always @(negedge clk_in) begin
        if (rd_tag_d) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 32'(cpu_din), 32'hDEAD);
            else chk("cpu_din", 32'(cpu_din), 32'(rd_q.pop_front()));
        end
        if (tx_valid && tx_ready) begin
            if (tx_q.size() == 0) chk("tx_unexpected", 32'(tx_data), 32'hDEAD);
            else chk("tx_data", 32'(tx_data), 32'(tx_q.pop_front()));
        end
    end

    task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d,
                         input logic tag, input logic [7:0] exp);
        cpu_a    = a;
        cpu_wr   = wr;
        cpu_dout = d;
        rd_tag   = tag;
        if (tag) rd_q.push_back(exp);
        @(negedge clk_in);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic cyc(input logic [31:0] a, input logic wr, input logic [7:0] d,
                       input logic tag, input logic [7:0] exp);
        drive(a, wr, d, tag, exp);
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(32'h0, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic preset_cnt(input logic [31:0] v);
        cpu_a  = 32'h0;
        cpu_wr = 1'b0;
        rd_tag = 1'b0;
        force dut.cnt_q = v;
        tick();
        release dut.cnt_q;
    endtask

    initial begin
        // Reset: outputs held quiet even with a RAM write presented.
        tick();
        tick();
        drive(32'h0000_0100, 1'b1, 8'h5A, 1'b0, 8'h00);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_rx_pop", 32'(rx_pop), 32'h0);
        chk("rst_buf_full", 32'(io_buffer_full), 32'h0);
        chk("rst_program_stop", 32'(program_stop), 32'h0);
        chk("rst_cpu_din", 32'(cpu_din), 32'h0);
        chk("rst_ram_wr", 32'(ram_wr), 32'h0);
        tick();
        rst_in = 1'b1;
        idle(2);

        // TX stream drops 0x00 writes.
        tx_ready = 1'b1;
        tx_q.push_back(8'h48);
        drive(32'h0003_0000, 1'b1, 8'h48, 1'b0, 8'h00);
        chk("io_wr_no_ram_wr", 32'(ram_wr), 32'h0);
        tick();
        cyc(32'h0003_0000, 1'b1, 8'h00, 1'b0, 8'h00);
        tx_q.push_back(8'h69);
        cyc(32'h0003_0000, 1'b1, 8'h69, 1'b0, 8'h00);
        idle(4);

        // RAM write then read, data one cycle after the address.
        drive(32'h0000_0100, 1'b1, 8'hA5, 1'b0, 8'h00);
        chk("ram_wr", 32'(ram_wr), 32'h1);
        chk("ram_a", 32'(ram_a), 32'h100);
        chk("ram_din", 32'(ram_din), 32'hA5);
        tick();
        cyc(32'h0000_0100, 1'b0, 8'h00, 1'b1, 8'hA5);
        idle(2);

        // Unmapped IO: reads zero, writes no effect.
        cyc(32'h0003_0008, 1'b0, 8'h00, 1'b1, 8'h00);
        cyc(32'h0003_0001, 1'b1, 8'h55, 1'b0, 8'h00);
        cyc(32'h0003_0002, 1'b0, 8'h00, 1'b1, 8'h00);
        idle(3);

        // RX read path (configuration dependent).
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        drive(32'h0003_0000, 1'b0, 8'h00, 1'b1, RX_EN ? 8'h77 : 8'h00);
        chk("rx_pop_valid", 32'(rx_pop), RX_EN ? 32'h1 : 32'h0);
        tick();
        rx_valid = 1'b0;
        drive(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h00);
        chk("rx_pop_empty", 32'(rx_pop), 32'h0);
        tick();
        idle(2);

        // Fill with TX stalled: full flag at 14, 17th write dropped.
        tx_ready = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            if (i <= 16) tx_q.push_back(8'(8'h10 + i));
            cyc(32'h0003_0000, 1'b1, 8'(8'h10 + i), 1'b0, 8'h00);
            chk("buf_full", 32'(io_buffer_full), (i >= 14) ? 32'h1 : 32'h0);
        end
        idle(1);
        tx_ready = 1'b1;
        idle(20);
        chk("drain_tx_valid", 32'(tx_valid), 32'h0);
        chk("drain_tx_q_left", 32'(tx_q.size()), 32'h0);

        // Reset in the middle of a drain discards the rest.
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tx_q.push_back(8'(8'hA0 + i));
            cyc(32'h0003_0000, 1'b1, 8'(8'hA0 + i), 1'b0, 8'h00);
        end
        tx_ready = 1'b1;
        idle(2);
        rst_in = 1'b0;
        tx_q.delete();
        drive(32'h0, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("middrain_rst_tx_valid", 32'(tx_valid), 32'h0);
        tick();
        tick();
        rst_in = 1'b1;
        idle(3);
        chk("middrain_after_tx_valid", 32'(tx_valid), 32'h0);

        // Counter snapshot across the 32-bit wrap.
        preset_cnt(32'hFFFF_FFFE);
        cyc(32'h0003_0004, 1'b0, 8'h00, 1'b1, 8'hFE);
        cyc(32'h0003_0005, 1'b0, 8'h00, 1'b1, 8'hFF);
        cyc(32'h0003_0006, 1'b0, 8'h00, 1'b1, 8'hFF);
        cyc(32'h0003_0007, 1'b0, 8'h00, 1'b1, 8'hFF);
        cyc(32'h0003_0004, 1'b0, 8'h00, 1'b1, 8'h02);
        cyc(32'h0003_0005, 1'b0, 8'h00, 1'b1, 8'h00);
        idle(2);

        // rdy_in low: no pop, no push, no RAM write, counter frozen.
        preset_cnt(32'h0000_1000);
        rdy_in   = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h33;
        drive(32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("rdy_low_rx_pop", 32'(rx_pop), 32'h0);
        tick();
        drive(32'h0000_0200, 1'b1, 8'h11, 1'b0, 8'h00);
        chk("rdy_low_ram_wr", 32'(ram_wr), 32'h0);
        tick();
        cyc(32'h0003_0000, 1'b1, 8'h5C, 1'b0, 8'h00);
        cyc(32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00);
        rdy_in   = 1'b1;
        rx_valid = 1'b0;
        cyc(32'h0003_0004, 1'b0, 8'h00, 1'b1, 8'h00);
        cyc(32'h0003_0005, 1'b0, 8'h00, 1'b1, 8'h10);
        idle(3);

        // Stop write: emits 0x00, sets sticky flag, blocks later IO writes.
        tx_q.push_back(8'h00);
        cyc(32'h0003_0004, 1'b1, 8'h99, 1'b0, 8'h00);
        idle(1);
        chk("program_stop_set", 32'(program_stop), 32'h1);
        cyc(32'h0003_0000, 1'b1, 8'h41, 1'b0, 8'h00);
        idle(4);
        chk("stop_tx_q_left", 32'(tx_q.size()), 32'h0);
        chk("program_stop_sticky", 32'(program_stop), 32'h1);
        rst_in = 1'b0;
        drive(32'h0, 1'b0, 8'h00, 1'b0, 8'h00);
        tick();
        chk("program_stop_rst", 32'(program_stop), 32'h0);
        rst_in = 1'b1;
        idle(2);
        chk("program_stop_after_rst", 32'(program_stop), 32'h0);

        chk("rd_q_left", 32'(rd_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1);
    end

endmodule
